bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000000, clock cycles per count step in RUN (range 2..2^24).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles per display digit slot (range 2..2^16).
REQ-003 SHALL have parameter MAX_COUNT, default 99, terminal count before wrap to 00 (range 1..99).
REQ-004 SHALL have parameter BLANK_LZ, default 1, nonzero = blank tens digit when tens==0.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  level, sampled each cycle: enter or resume RUN.
REQ-008 stop  in  1  level, sampled each cycle: RUN -> HOLD.
REQ-009 clear  in  1  level, sampled each cycle: count to 00, go IDLE.
REQ-010 step  in  1  level, sampled each cycle: single increment while in HOLD.
REQ-011 seg  out  7  segments a..g as seg[6]..seg[0], active-low (0 = lit).
REQ-012 an  out  2  digit enables, active-low; an[0] = ones, an[1] = tens.
REQ-013 ones  out  4  BCD ones digit of current count.
REQ-014 tens  out  4  BCD tens digit of current count.
REQ-015 wrap  out  1  one-cycle pulse when count wraps MAX_COUNT -> 00.
REQ-016 running  out  1  high while FSM in RUN.

Function
REQ-017 FSM states SHALL be IDLE, RUN, HOLD.
REQ-018 Input priority SHALL be clear > stop > start > step, one action per cycle.
REQ-019 Transitions: any --clear--> IDLE; IDLE --start--> RUN; RUN --stop--> HOLD; HOLD --start--> RUN; HOLD --step--> HOLD with one increment; stop in IDLE/HOLD and step in IDLE/RUN SHALL be ignored.
REQ-020 Prescaler SHALL count 0..PRESCALE-1 only in RUN, freeze in HOLD, zero on clear/IDLE.
REQ-021 Increment SHALL occur in RUN on the edge where prescaler == PRESCALE-1; first increment PRESCALE cycles after entering RUN from IDLE.
REQ-022 Increment: ones 9 -> 0 with tens+1; count == MAX_COUNT -> 00 and wrap high the following cycle only.
REQ-023 Stop and terminal prescaler in same cycle: stop wins, increment suppressed, prescaler frozen at terminal, increment fires on first RUN cycle after resume.
REQ-024 Step increment SHALL be visible on ones/tens one cycle after step sampled; step held high increments once per cycle.
REQ-025 Scanner SHALL free-run in all states: counter 0..SCAN_DIV-1, active digit toggles at terminal; ones slot first after reset.
REQ-026 seg and an SHALL be registered and update on the same edge (no ghosting); an = 2'b10 in ones slot, 2'b01 in tens slot.
REQ-027 Patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; codes 10-15 SHALL give 1111111.
REQ-028 With BLANK_LZ nonzero and tens==0, tens slot SHALL drive seg = 1111111 with an still 2'b01.

Reset
REQ-029 rst SHALL force state IDLE, prescaler 0, scan counter 0, ones slot, ones=tens=0, wrap=0, running=0, seg=1111111, an=2'b11 on the next edge.
REQ-030 rst mid-RUN or mid-step SHALL discard any pending increment; rst SHALL override all inputs.
REQ-031 First scan slot SHALL drive an=2'b10 on the first edge after rst deasserts.

Structure
REQ-032 Shared package bcd_seq_pkg SHALL hold the state enum, 7-bit segment pattern constants and the blank constant.
REQ-033 Combinational BCD-to-segment lookup SHALL be sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out), one instance, time-shared between digits.

Verification (PRESCALE=4, SCAN_DIV=3, MAX_COUNT=99, BLANK_LZ=1)
REQ-034 rst then start 1 cycle -> running=1 next cycle, count 01 exactly 4 cycles after start sampled, 02 after 8.
REQ-035 Preload to 99 in HOLD by steps, then one step -> count 00, wrap high exactly one cycle.
REQ-036 MAX_COUNT=12, RUN from 00 -> sequence 00..12, then 00 with wrap pulse; BCD never shows ones > 9.
REQ-037 stop asserted on terminal prescaler cycle -> HOLD, count unchanged; start -> increment on first RUN cycle.
REQ-038 start+stop+clear same cycle in RUN -> IDLE, count 00, running 0; rst mid-RUN at count 37 -> count 00, seg=1111111, an=2'b11.
REQ-039 Count 05 -> an alternates 10/01 every 3 cycles; ones slot seg=0100100, tens slot seg=1111111 (blanked).

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the BCD up-counter / two-digit display
// controller: FSM state encoding, active-low 7-segment patterns and the
// digit-enable codes.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Segments a..g on bits [6:0], 0 = lit
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit enables, active-low; an[0] = ones, an[1] = tens
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// Control inputs and display/count outputs of bcd_seq_ctrl. The master side
// drives the level controls; the slave (the controller) drives the display.
interface bcd_seq_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       step;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       wrap;
  logic       running;

  modport master (
    output start, stop, clear, step,
    input  seg, an, ones, tens, wrap, running
  );

  modport slave (
    input  start, stop, clear, step,
    output seg, an, ones, tens, wrap, running
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes go dark.
module bcd_to_seg7
  import bcd_seq_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pattern lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Two-digit BCD up-counter with IDLE/RUN/HOLD control, a run-time prescaler,
// single-step in HOLD and a free-running multiplexed 7-segment scanner that
// shares one decoder between the two digits.
module bcd_seq_ctrl
  import bcd_seq_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1000000,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned MAX_COUNT = 99,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seq_ctrl_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [3:0]    MAX_ONES  = 4'(MAX_COUNT % 10);
  localparam bit            BLANK_EN  = (BLANK_LZ != 0);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic          wrap_q, wrap_d;
  logic          running_q;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;      // 0 = ones slot, 1 = tens slot
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          inc_s;
  logic [3:0]    digit_s;
  logic [6:0]    dec_s;

  // FSM next state and prescaler; ignored inputs never block lower-priority ones
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    inc_s   = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (bus.start) state_d = ST_RUN;
          else           state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_HOLD;            // prescaler frozen, even at terminal
          end else if (presc_q == PRE_LAST) begin
            presc_d = '0;
            inc_s   = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.start)     state_d = ST_RUN;
          else if (bus.step) inc_s   = 1'b1;
          else               state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // BCD count update and wrap detection
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (bus.clear) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc_s) begin
      if (ones_q == MAX_ONES && tens_q == MAX_TENS) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      ones_d = ones_q;
    end
  end

  // Scanner slot counter and digit select
  always_comb begin
    scan_d = scan_q + SW'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end else begin
      sel_d  = sel_q;
    end
  end

  assign digit_s = sel_q ? tens_q : ones_q;

  bcd_to_seg7 u_seg7 (
    .bcd_i (digit_s),
    .seg_o (dec_s)
  );

  // Segment and enable pair for the current slot, with leading-zero blanking
  always_comb begin
    an_d  = sel_q ? AN_TENS : AN_ONES;
    seg_d = dec_s;
    if (sel_q && BLANK_EN && tens_q == 4'd0) seg_d = SEG_BLANK;
    else                                     seg_d = dec_s;
  end

  // State, count and display registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      scan_q    <= '0;
      sel_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      scan_q    <= scan_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.ones    = ones_q;
  assign bus.tens    = tens_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Bench for bcd_seq_ctrl: two instances (MAX_COUNT 99 and 12) share one
// stimulus stream; an integer-count reference model predicts every output on
// every cycle, and a few literal expectations pin the model itself.
module tb_bcd_seq_ctrl;

  localparam int PRE = 4;
  localparam int SD  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_seq_ctrl_if bus0 ();
  bcd_seq_ctrl_if bus1 ();

  bcd_seq_ctrl #(.PRESCALE(PRE), .SCAN_DIV(SD), .MAX_COUNT(99), .BLANK_LZ(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  bcd_seq_ctrl #(.PRESCALE(PRE), .SCAN_DIV(SD), .MAX_COUNT(12), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // reference model state: mode 0 idle, 1 run, 2 hold; count as a plain integer
  int         m_max  [2] = '{99, 12};
  int         m_mode [2];
  int         m_cnt  [2];
  int         m_pre  [2];
  int         m_k    [2];
  logic       m_wrap [2];
  logic [6:0] m_seg  [2];
  logic [1:0] m_an   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic s, input logic p,
                            input logic c, input logic t);
    bit inc;
    bit slot;
    if (r) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_k[i] = 0;
      m_wrap[i] = 1'b0; m_seg[i] = 7'h7F; m_an[i] = 2'b11;
      return;
    end
    m_k[i]++;
    slot = (((m_k[i] - 1) / SD) % 2) == 1;
    m_an[i] = slot ? 2'b01 : 2'b10;
    if (slot) m_seg[i] = (m_cnt[i] / 10 == 0) ? 7'h7F : pat[m_cnt[i] / 10];
    else      m_seg[i] = pat[m_cnt[i] % 10];
    inc = 1'b0;
    if (c) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
    end else begin
      case (m_mode[i])
        0: if (s) m_mode[i] = 1;
        1: begin
          if (p) m_mode[i] = 2;
          else if (m_pre[i] == PRE - 1) begin m_pre[i] = 0; inc = 1'b1; end
          else m_pre[i]++;
        end
        default: begin
          if (s) m_mode[i] = 1;
          else if (t) inc = 1'b1;
        end
      endcase
    end
    m_wrap[i] = inc && (m_cnt[i] == m_max[i]);
    if (inc) m_cnt[i] = (m_cnt[i] == m_max[i]) ? 0 : m_cnt[i] + 1;
  endtask

  task automatic cmp_inst(input int i, input logic [6:0] seg, input logic [1:0] an,
                          input logic [3:0] ones, input logic [3:0] tens,
                          input logic wrap, input logic running);
    chk($sformatf("u%0d.ones", i), 32'(ones), 32'(m_cnt[i] % 10));
    chk($sformatf("u%0d.tens", i), 32'(tens), 32'(m_cnt[i] / 10));
    chk($sformatf("u%0d.wrap", i), 32'(wrap), 32'(m_wrap[i]));
    chk($sformatf("u%0d.running", i), 32'(running), 32'(m_mode[i] == 1));
    chk($sformatf("u%0d.seg", i), 32'(seg), 32'(m_seg[i]));
    chk($sformatf("u%0d.an", i), 32'(an), 32'(m_an[i]));
    chk($sformatf("u%0d.ones_bcd", i), 32'(ones <= 4'd9), 32'd1);
  endtask

  task automatic cycle(input logic r, input logic s, input logic p, input logic c, input logic t);
    rst = r;
    bus0.start = s; bus0.stop = p; bus0.clear = c; bus0.step = t;
    bus1.start = s; bus1.stop = p; bus1.clear = c; bus1.step = t;
    @(posedge clk);
    model_step(0, r, s, p, c, t);
    model_step(1, r, s, p, c, t);
    @(negedge clk);
    cmp_inst(0, bus0.seg, bus0.an, bus0.ones, bus0.tens, bus0.wrap, bus0.running);
    cmp_inst(1, bus1.seg, bus1.an, bus1.ones, bus1.tens, bus1.wrap, bus1.running);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int wraps;
    // reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.seg", 32'(bus0.seg), 32'h7F);
    chk("rst.an", 32'(bus0.an), 32'h3);
    chk("rst.count", 32'({bus0.tens, bus0.ones}), 32'h00);
    chk("rst.running", 32'(bus0.running), 32'd0);

    // start: running next cycle, 01 after 4 cycles, 02 after 8
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start.running", 32'(bus0.running), 32'd1);
    idle(3);
    chk("start.ones@3", 32'(bus0.ones), 32'd0);
    idle(1);
    chk("start.ones@4", 32'(bus0.ones), 32'd1);
    idle(4);
    chk("start.ones@8", 32'(bus0.ones), 32'd2);

    // stop on the terminal prescaler cycle, then resume
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stop_term.ones", 32'(bus0.ones), 32'd2);
    chk("stop_term.running", 32'(bus0.running), 32'd0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume.ones", 32'(bus0.ones), 32'd2);
    idle(1);
    chk("resume.inc", 32'(bus0.ones), 32'd3);

    // step to 99 in HOLD, then wrap
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    steps(96);
    chk("step99", 32'({bus0.tens, bus0.ones}), 32'h99);
    steps(1);
    chk("wrap.count", 32'({bus0.tens, bus0.ones}), 32'h00);
    chk("wrap.pulse", 32'(bus0.wrap), 32'd1);
    idle(1);
    chk("wrap.once", 32'(bus0.wrap), 32'd0);

    // count 05: ones slot shows 5, tens slot blanked
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear.running", 32'(bus0.running), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    steps(5);
    idle(1);
    for (int j = 0; j < 12; j++) begin
      idle(1);
      if (bus0.an == 2'b10) chk("d05.ones_seg", 32'(bus0.seg), 32'h24);
      else begin
        chk("d05.an_tens", 32'(bus0.an), 32'h1);
        chk("d05.tens_seg", 32'(bus0.seg), 32'h7F);
      end
    end

    // MAX_COUNT=12 instance runs through 00..12 and wraps once
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wraps = 0;
    for (int j = 0; j < 60; j++) begin
      idle(1);
      if (bus1.wrap) wraps++;
    end
    chk("max12.wraps", 32'(wraps), 32'd1);
    chk("max12.count", 32'({bus1.tens, bus1.ones}), 32'h02);
    chk("max99.count", 32'({bus0.tens, bus0.ones}), 32'h15);

    // start+stop+clear together in RUN
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ssc.running", 32'(bus0.running), 32'd0);
    chk("ssc.count", 32'({bus0.tens, bus0.ones}), 32'h00);

    // reset mid-RUN at 37
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    steps(37);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("pre_rst.count", 32'({bus0.tens, bus0.ones}), 32'h37);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_run.count", 32'({bus0.tens, bus0.ones}), 32'h00);
    chk("rst_run.seg", 32'(bus0.seg), 32'h7F);
    chk("rst_run.an", 32'(bus0.an), 32'h3);
    chk("rst_run.running", 32'(bus0.running), 32'd0);
    idle(1);
    chk("post_rst.an", 32'(bus0.an), 32'h2);

    // randomized control levels
    for (int j = 0; j < 3000; j++) begin
      cycle($urandom_range(199) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
            $urandom_range(49) == 0, $urandom_range(2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
